// File: rtl/data_mem_resp.sv
// Memory-side responder for a cache controller: single-word writes and
// line-fill reads, each completed after a programmable latency with a ready pulse.
module data_mem_resp #(
  parameter int cache_width  = 128,
  parameter int memory_width = 32,
  parameter int memory_depth = 1024,
  parameter int latency      = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            rd_en,
  input  logic                            wr_en,
  input  logic [$clog2(memory_depth)-1:0] addr,
  input  logic [memory_width-1:0]         wr_data,
  output logic [cache_width-1:0]          rd_block,
  output logic                            ready,
  output logic                            busy
);

  localparam int WORDS = cache_width / memory_width;
  localparam int AW    = $clog2(memory_depth);
  localparam int IW    = $clog2(WORDS);
  localparam int CW    = $clog2(latency + 1);

  typedef enum logic [2:0] {IDLE, WR_WAIT, RD_WAIT, RD_FILL, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [AW-1:0]           req_addr;
  logic [memory_width-1:0] req_data;
  logic [IW-1:0]           idx;
  logic                    commit;

  logic [memory_width-1:0] mem [memory_depth];

  assign commit = (state == WR_WAIT) && (cnt == '0);

  // Array is deliberately left out of reset; a reset edge suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (reset_n && commit)
      mem[req_addr] <= req_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      req_addr <= '0;
      req_data <= '0;
      idx      <= '0;
      rd_block <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            req_addr <= addr;
            req_data <= wr_data;
            cnt      <= CW'(latency - 1);
            busy     <= 1'b1;
            state    <= WR_WAIT;
          end else if (rd_en) begin
            req_addr <= {addr[AW-1:IW], {IW{1'b0}}};
            cnt      <= CW'(latency - 1);
            busy     <= 1'b1;
            state    <= RD_WAIT;
          end
        end
        WR_WAIT: begin
          if (cnt == '0) begin
            ready <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            idx   <= '0;
            state <= RD_FILL;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RD_FILL: begin
          // Base is line-aligned, so concatenating the index replaces base+idx.
          rd_block[memory_width*idx +: memory_width] <= mem[{req_addr[AW-1:IW], idx}];
          idx <= idx + IW'(1);
          if (idx == IW'(WORDS - 1)) begin
            ready <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: a latency=4 instance and a latency=1
// instance share clock, reset, address and data; enables are steered by sel.
module tb_data_mem_resp;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         rd_en = 1'b0;
  logic         wr_en = 1'b0;
  logic         sel = 1'b0;
  logic [9:0]   addr = '0;
  logic [31:0]  wr_data = '0;

  logic         rd0, wr0, rd1, wr1;
  logic [127:0] blk0, blk1, blk_s;
  logic         rdy0, rdy1, busy0, busy1, rdy_s, busy_s;
  logic [127:0] b;

  int n_assert = 0;
  int n_fail   = 0;

  assign rd0    = rd_en & ~sel;
  assign wr0    = wr_en & ~sel;
  assign rd1    = rd_en & sel;
  assign wr1    = wr_en & sel;
  assign rdy_s  = sel ? rdy1 : rdy0;
  assign busy_s = sel ? busy1 : busy0;
  assign blk_s  = sel ? blk1 : blk0;

  always #5 clk = ~clk;

  data_mem_resp #(.cache_width(128), .memory_width(32), .memory_depth(1024), .latency(4)) dut (
    .clk(clk), .reset_n(reset_n), .rd_en(rd0), .wr_en(wr0), .addr(addr),
    .wr_data(wr_data), .rd_block(blk0), .ready(rdy0), .busy(busy0)
  );

  data_mem_resp #(.cache_width(128), .memory_width(32), .memory_depth(1024), .latency(1)) dut_fast (
    .clk(clk), .reset_n(reset_n), .rd_en(rd1), .wr_en(wr1), .addr(addr),
    .wr_data(wr_data), .rd_block(blk1), .ready(rdy1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in the current (IDLE) cycle and returns in the IDLE
  // cycle after ready, so a following call is a back-to-back request.
  task automatic request(input bit wr, input bit rd, input logic [9:0] a,
                         input logic [31:0] d, input int exp_cycles, input bit scramble);
    int n;
    addr    = a;
    wr_data = d;
    wr_en   = wr;
    rd_en   = rd;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (scramble) begin
      addr    = a + 10'd1;
      wr_data = 32'hFFFF_FFFF;
    end
    n = 1;
    while (rdy_s !== 1'b1 && n < 40) begin
      check("busy_wait", 128'(busy_s), 128'(1));
      tick();
      n++;
    end
    check("ready_cycle", 128'(n), 128'(exp_cycles));
    check("ready_hi", 128'(rdy_s), 128'(1));
    check("busy_at_ready", 128'(busy_s), 128'(1));
    tick();
    check("ready_one_cycle", 128'(rdy_s), 128'(0));
    check("busy_dropped", 128'(busy_s), 128'(0));
  endtask

  initial begin
    // Reset state of both instances
    tick();
    tick();
    check("rst_ready0", 128'(rdy0), 128'(0));
    check("rst_busy0", 128'(busy0), 128'(0));
    check("rst_block0", blk0, '0);
    check("rst_ready1", 128'(rdy1), 128'(0));
    check("rst_busy1", 128'(busy1), 128'(0));
    check("rst_block1", blk1, '0);
    reset_n = 1'b1;

    // Single write, latency 4
    request(1'b1, 1'b0, 10'h005, 32'hDEAD_BEEF, 5, 1'b0);

    // Fill line 0x008 and read it back with an unaligned address
    request(1'b1, 1'b0, 10'h008, 32'h0000_0011, 5, 1'b0);
    request(1'b1, 1'b0, 10'h009, 32'h0000_0022, 5, 1'b0);
    request(1'b1, 1'b0, 10'h00A, 32'h0000_0033, 5, 1'b0);
    request(1'b1, 1'b0, 10'h00B, 32'h0000_0044, 5, 1'b0);
    request(1'b0, 1'b1, 10'h00A, 32'h0, 9, 1'b0);
    check("line_008", blk0, 128'h00000044_00000033_00000022_00000011);

    // Both enables: write wins, rd_block untouched
    request(1'b1, 1'b1, 10'h010, 32'hA5A5_A5A5, 5, 1'b0);
    check("block_kept", blk0, 128'h00000044_00000033_00000022_00000011);
    request(1'b0, 1'b1, 10'h013, 32'h0, 9, 1'b0);
    b = blk0;
    check("line_010_w0", 128'(b[31:0]), 128'(32'hA5A5_A5A5));

    // Earlier word 0x005 lands in word 1 of line 0x004
    request(1'b0, 1'b1, 10'h007, 32'h0, 9, 1'b0);
    b = blk0;
    check("line_004_w1", 128'(b[63:32]), 128'(32'hDEAD_BEEF));

    // Address/data changed during WR_WAIT must not affect the write
    request(1'b1, 1'b0, 10'h021, 32'h0BAD_F00D, 5, 1'b0);
    request(1'b1, 1'b0, 10'h022, 32'h2222_2222, 5, 1'b0);
    request(1'b1, 1'b0, 10'h023, 32'h3333_3333, 5, 1'b0);
    request(1'b1, 1'b0, 10'h020, 32'h1234_5678, 5, 1'b1);
    request(1'b0, 1'b1, 10'h020, 32'h0, 9, 1'b0);
    check("line_020", blk0, 128'h33333333_22222222_0BADF00D_12345678);

    // Reset asserted for one cycle while in RD_FILL
    addr  = 10'h008;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    repeat (5) tick();
    check("fill_busy", 128'(busy0), 128'(1));
    reset_n = 1'b0;
    tick();
    check("abort_busy", 128'(busy0), 128'(0));
    check("abort_ready", 128'(rdy0), 128'(0));
    check("abort_block", blk0, '0);
    reset_n = 1'b1;
    repeat (12) begin
      tick();
      check("abort_no_ready", 128'(rdy0), 128'(0));
    end

    // latency=1 instance: write then back-to-back read
    sel = 1'b1;
    request(1'b1, 1'b0, 10'h030, 32'hCAFE_F00D, 2, 1'b0);
    request(1'b0, 1'b1, 10'h031, 32'h0, 6, 1'b0);
    b = blk1;
    check("fast_line_030_w0", 128'(b[31:0]), 128'(32'hCAFE_F00D));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Data-memory responder that sits behind the cache controller on its memory side. Accepts single-word write requests (write-through and write-around) and block-fill read requests (read miss). Applies a programmable access latency, then answers with a one-cycle `ready` pulse. Reads return a full cache line assembled from consecutive memory words.

## Interface
- `cache_width`, default 128: cache line width in bits; `WORDS = cache_width/memory_width` (4 by default).
- `memory_width`, default 32: word width in bits.
- `memory_depth`, default 1024: number of words. `AW = clog2(memory_depth)` (10 by default).
- `latency`, default 4: wait cycles before any array access. Legal range ≥1.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `rd_en` in 1: line-fill request (sampled only in IDLE).
- `wr_en` in 1: word write request (sampled only in IDLE).
- `addr` in AW: word address of the request.
- `wr_data` in memory_width: write word.
- `rd_block` out cache_width: filled line. Word i is at `[memory_width*i +: memory_width]`.
- `ready` out 1: one-cycle completion pulse.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, WR_WAIT, RD_WAIT, RD_FILL, DONE.
- IDLE:
  - If `wr_en`: capture `addr` and `wr_data`, load the wait counter with `latency-1`, go to WR_WAIT.
  - Else if `rd_en`: capture `addr` with the low clog2(WORDS) bits forced to 0 (line-aligned base), load the counter, go to RD_WAIT.
  - Otherwise stay in IDLE.
  - Write has priority when both enables are high. The read is dropped, not queued.
- WR_WAIT: decrement the counter. At counter==0, write the captured word to `mem[addr]` on that edge and go to DONE.
- RD_WAIT: decrement the counter. At counter==0, clear the fill index and go to RD_FILL.
- RD_FILL: one word per cycle. `rd_block` word[idx] <= `mem[base+idx]`, then idx++. After word WORDS-1 is loaded, go to DONE.
- DONE: `ready`=1 for this cycle only, then unconditionally go to IDLE.
  - Requests are ignored in DONE.
  - An enable still high in the following IDLE cycle is taken as a new request. The requester must drop its enables once it sees `ready`.
- `rd_block`:
  - Holds its value from read completion until the next read's RD_FILL begins overwriting it.
  - Writes never change `rd_block`, even when they hit the same line.
- Inputs are sampled only on the accept edge. Changes to `addr`, `wr_data` or the enables while busy have no effect.
- Array is not cleared by reset. Contents are undefined until written.
- Address arithmetic is AW bits wide. A line base is always aligned, so `base+idx` never wraps.

## Timing
- Reset: on any edge with `reset_n`=0, state is IDLE and `ready`=0, `busy`=0, `rd_block`=0.
  - Reset mid-operation aborts it. A write not yet committed is lost, and no `ready` is issued.
- Accept edge E0 (IDLE, enable high):
  - `busy`=1 from the cycle after E0.
  - Write: array updated on edge E0+latency; `ready`=1 in the cycle after that edge. Write-to-`ready` is latency+1 cycles after the request cycle.
  - Read: RD_FILL spans edges E0+latency+1 through E0+latency+WORDS; `ready`=1 in the cycle after. Read-to-`ready` is latency+WORDS+1 cycles after the request cycle. `rd_block` holds the complete line while `ready`=1.
- `busy` drops together with `ready`'s falling edge, i.e. on return to IDLE.
- Fastest back-to-back: a new request can be accepted in the cycle right after the `ready` cycle.
- A read issued immediately after a write to the same line returns the new data, because the write commits before DONE.

## Test plan
- Reset, then write `addr`=0x005, `wr_data`=0xDEADBEEF (latency=4) -> `ready` pulses exactly 5 cycles after the request cycle, for one cycle; `busy`=1 for 5 cycles.
- Write 0x11, 0x22, 0x33, 0x44 to addresses 0x008–0x00B, then read with `addr`=0x00A -> `ready` 9 cycles after the request; `rd_block`=0x00000044_00000033_00000022_00000011.
- `rd_en`=`wr_en`=1, `addr`=0x010, `wr_data`=0xA5A5A5A5 -> write-only timing; `rd_block` unchanged; a later read of line 0x010 returns word0=0xA5A5A5A5.
- Start a read, assert `reset_n`=0 during RD_FILL for one cycle -> next cycle `busy`=0, `ready`=0, `rd_block`=0; `ready` is never asserted for the aborted read.
- latency=1 build: write then read back-to-back (new request in the cycle after `ready`) -> write `ready` 2 cycles after its request, read `ready` 6 cycles after its request, data matches.
- Change `addr` and `wr_data` while WR_WAIT -> originally captured address and data are written; no other location changes.
